character_feeder_plane: RTL and testbench

- Text-console character buffer: a feeder front end takes one character code per strobe, manages a cursor, and writes the code into a 16-row x 64-column character plane.
- Scrolls the plane up one row when the cursor runs off the bottom, and clears the plane on request.
- The plane has an independent read port for the video/glyph renderer, addressed in visible (scrolled) coordinates.

---
 rtl/character_feeder_plane.sv | 158 +++++++++++++++
 tb/tb_character_feeder_plane.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/character_feeder_plane.sv
// Text-console character plane: cursor-driven feeder, scrolling 16x64 RAM and a
// registered renderer read port. Define CHARACTER_FEEDER_CTRL_EN to decode LF/CR/BS/FF.
module character_feeder_plane #(
  parameter int                 ROWS       = 16,
  parameter int                 COLS       = 64,
  parameter int                 CHAR_W     = 8,
  parameter logic [CHAR_W-1:0]  BLANK_CHAR = '0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       we,
  input  logic [CHAR_W-1:0]          char_in,
  input  logic [$clog2(ROWS)-1:0]    rd_row,
  input  logic [$clog2(COLS)-1:0]    rd_col,
  output logic [CHAR_W-1:0]          char_out,
  output logic [$clog2(ROWS)-1:0]    cur_row,
  output logic [$clog2(COLS)-1:0]    cur_col,
  output logic                       push_up,
  output logic                       reset_call
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int LW = CW + 1;

`ifdef CHARACTER_FEEDER_CTRL_EN
  localparam logic [CHAR_W-1:0] CODE_BS = CHAR_W'(8'h08);
  localparam logic [CHAR_W-1:0] CODE_LF = CHAR_W'(8'h0A);
  localparam logic [CHAR_W-1:0] CODE_FF = CHAR_W'(8'h0C);
  localparam logic [CHAR_W-1:0] CODE_CR = CHAR_W'(8'h0D);
  logic reset_call_q, reset_call_d;
`endif

  logic [RW-1:0]     cur_row_q, cur_row_d;
  logic [CW-1:0]     cur_col_q, cur_col_d;
  logic [RW-1:0]     top_q, top_d;
  logic [LW-1:0]     len_q [ROWS];
  logic [LW-1:0]     len_d [ROWS];
  logic              push_up_q, push_up_d;
  logic              rd_valid_q;
  logic [CHAR_W-1:0] ram_rd_q;
  logic [CHAR_W-1:0] mem [ROWS*COLS];

  logic              printable;
  logic              advance;
  logic              wr_en;
  logic [RW-1:0]     wr_phys;
  logic [RW-1:0]     rd_phys;
  logic [LW-1:0]     col_plus1;

  assign wr_phys   = cur_row_q + top_q;
  assign rd_phys   = rd_row + top_q;
  assign col_plus1 = {1'b0, cur_col_q} + LW'(1);

  // NOTE: every variable gets its hold value first, so no path through the
  // block can leave one unassigned and infer a latch.
  always_comb begin
    cur_row_d = cur_row_q;
    cur_col_d = cur_col_q;
    top_d     = top_q;
    len_d     = len_q;
    push_up_d = 1'b0;
    printable = 1'b0;
    advance   = 1'b0;
    wr_en     = 1'b0;
`ifdef CHARACTER_FEEDER_CTRL_EN
    reset_call_d = 1'b0;
`endif

    if (we) begin
`ifdef CHARACTER_FEEDER_CTRL_EN
      case (char_in)
        CODE_LF: begin
          cur_col_d = '0;
          advance   = 1'b1;
        end
        CODE_CR: cur_col_d = '0;
        CODE_BS: if (cur_col_q != '0) cur_col_d = cur_col_q - CW'(1);
        CODE_FF: begin
          for (int i = 0; i < ROWS; i++) len_d[i] = '0;
          top_d        = '0;
          cur_row_d    = '0;
          cur_col_d    = '0;
          reset_call_d = 1'b1;
        end
        default: printable = 1'b1;
      endcase
`else
      printable = 1'b1;
`endif
    end

    if (printable) begin
      wr_en = 1'b1;
      if (len_q[wr_phys] < col_plus1) len_d[wr_phys] = col_plus1;
      if (cur_col_q == CW'(COLS-1)) begin
        cur_col_d = '0;
        advance   = 1'b1;
      end else begin
        cur_col_d = cur_col_q + CW'(1);
      end
    end

    // Scrolling: the old top physical row becomes the new, blank bottom row.
    if (advance) begin
      if (cur_row_q != RW'(ROWS-1)) begin
        cur_row_d = cur_row_q + RW'(1);
      end else begin
        top_d        = top_q + RW'(1);
        len_d[top_q] = '0;
        push_up_d    = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_row_q  <= '0;
      cur_col_q  <= '0;
      top_q      <= '0;
      push_up_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      for (int i = 0; i < ROWS; i++) len_q[i] <= '0;
    end else begin
      cur_row_q  <= cur_row_d;
      cur_col_q  <= cur_col_d;
      top_q      <= top_d;
      push_up_q  <= push_up_d;
      rd_valid_q <= ({1'b0, rd_col} < len_q[rd_phys]);
      len_q      <= len_d;
    end
  end

`ifdef CHARACTER_FEEDER_CTRL_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) reset_call_q <= 1'b0;
    else       reset_call_q <= reset_call_d;
  end
  assign reset_call = reset_call_q;
`else
  assign reset_call = 1'b0;
`endif

  // NOTE: the RAM is deliberately not reset; the per-row lengths decide which
  // cells are visible, which keeps the array BRAM-inferable.
  always_ff @(posedge clock) begin
    if (wr_en) mem[{wr_phys, cur_col_q}] <= char_in;
    ram_rd_q <= mem[{rd_phys, rd_col}];
  end

  assign char_out = rd_valid_q ? ram_rd_q : BLANK_CHAR;
  assign cur_row  = cur_row_q;
  assign cur_col  = cur_col_q;
  assign push_up  = push_up_q;

endmodule

// File: tb/tb_character_feeder_plane.sv
// Directed bench for character_feeder_plane; read data checked through a scoreboard
// queue. Control-code tests run when CHARACTER_FEEDER_CTRL_EN is defined.
module tb_character_feeder_plane;

  logic       clock = 1'b0;
  logic       reset;
  logic       we;
  logic [7:0] char_in;
  logic [3:0] rd_row;
  logic [5:0] rd_col;
  logic [7:0] char_out;
  logic [3:0] cur_row;
  logic [5:0] cur_col;
  logic       push_up;
  logic       reset_call;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q [$];
  int         pu_cnt;
  int         pu_at;
  int         rc_cnt;

  character_feeder_plane dut (
    .clock      (clock),
    .reset      (reset),
    .we         (we),
    .char_in    (char_in),
    .rd_row     (rd_row),
    .rd_col     (rd_col),
    .char_out   (char_out),
    .cur_row    (cur_row),
    .cur_col    (cur_col),
    .push_up    (push_up),
    .reset_call (reset_call)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic feed(input logic [7:0] c);
    we      = 1'b1;
    char_in = c;
    step();
    we      = 1'b0;
  endtask

  task automatic read(input logic [3:0] r, input logic [5:0] c, input logic [7:0] exp, input string tag);
    rd_row = r;
    rd_col = c;
    exp_q.push_back(exp);
    step();
    check(tag, char_out, exp_q.pop_front());
  endtask

  task automatic cursor(input logic [3:0] r, input logic [5:0] c, input string tag);
    check({tag, "_row"}, cur_row, r);
    check({tag, "_col"}, cur_col, c);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    we      = 1'b0;
    char_in = '0;
    rd_row  = '0;
    rd_col  = '0;
    #12;
    cursor(4'd0, 6'd0, "reset_cursor");
    check("reset_char_out", char_out, 8'h00);
    check("reset_push_up", push_up, 1'b0);
    check("reset_reset_call", reset_call, 1'b0);
    reset = 1'b0;
    read(4'd0, 6'd0, 8'h00, "reset_read_00");

    // Read and write of the same cell on one edge returns the pre-write value.
    rd_row = 4'd0;
    rd_col = 6'd0;
    we     = 1'b1;
    char_in = 8'h5A;
    exp_q.push_back(8'h00);
    step();
    we = 1'b0;
    check("rw_same_cell", char_out, exp_q.pop_front());
    read(4'd0, 6'd0, 8'h5A, "rw_after_write");

`ifndef CHARACTER_FEEDER_CTRL_EN
    pulse_reset();
    pu_cnt = 0;
    rc_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      feed(i[7:0]);
      if (push_up) pu_cnt++;
      if (reset_call) rc_cnt++;
    end
    check("fill256_push_up_count", pu_cnt, 0);
    check("fill256_reset_call_count", rc_cnt, 0);
    cursor(4'd4, 6'd0, "fill256_cursor");
    read(4'd0, 6'd5,  8'd5,   "fill256_r0c5");
    read(4'd3, 6'd63, 8'd255, "fill256_r3c63");
    read(4'd1, 6'd0,  8'd64,  "fill256_r1c0");
    read(4'd4, 6'd0,  8'd0,   "fill256_r4c0_blank");

    pulse_reset();
    pu_cnt = 0;
    pu_at  = -1;
    for (int i = 0; i < 1024; i++) begin
      feed(i[7:0]);
      if (push_up) begin
        pu_cnt++;
        pu_at = i;
      end
    end
    check("scroll_push_up_count", pu_cnt, 1);
    check("scroll_push_up_index", pu_at, 1023);
    cursor(4'd15, 6'd0, "scroll_cursor");
    read(4'd0,  6'd0,  8'd64,  "scroll_r0c0");
    check("scroll_push_up_single", push_up, 1'b0);
    read(4'd15, 6'd0,  8'd0,   "scroll_r15c0_blank");
    read(4'd14, 6'd63, 8'd255, "scroll_r14c63");
    read(4'd1,  6'd10, 8'd138, "scroll_r1c10");
`else
    pulse_reset();
    feed("A");
    feed("B");
    feed(8'h0A);
    feed("C");
    cursor(4'd1, 6'd1, "ctrl_lf_cursor");
    read(4'd0, 6'd1, "B",   "ctrl_r0c1");
    read(4'd1, 6'd0, "C",   "ctrl_r1c0");
    read(4'd0, 6'd2, 8'h00, "ctrl_r0c2_blank");
    read(4'd0, 6'd2, 8'h00, "ctrl_lf_not_stored");

    feed(8'h0C);
    check("ctrl_ff_reset_call_hi", reset_call, 1'b1);
    cursor(4'd0, 6'd0, "ctrl_ff_cursor");
    read(4'd0, 6'd0, 8'h00, "ctrl_ff_r0c0_blank");
    check("ctrl_ff_reset_call_lo", reset_call, 1'b0);
    read(4'd1, 6'd0, 8'h00, "ctrl_ff_r1c0_blank");

    feed(8'h08);
    cursor(4'd0, 6'd0, "ctrl_bs_saturate");
    feed("X");
    feed(8'h08);
    cursor(4'd0, 6'd0, "ctrl_bs_back");
    feed("Y");
    cursor(4'd0, 6'd1, "ctrl_bs_overwrite_cursor");
    read(4'd0, 6'd0, "Y", "ctrl_bs_overwrite");

    feed("Q");
    feed(8'h0D);
    cursor(4'd0, 6'd0, "ctrl_cr_cursor");
    read(4'd0, 6'd1, "Q", "ctrl_cr_kept");
`endif

    // Reset in the middle of a write stream acts without a clock edge.
    pulse_reset();
    for (int i = 0; i < 5; i++) feed(8'h40 + i[7:0]);
    read(4'd0, 6'd2, 8'h42, "midrst_pre_read");
    rd_row  = 4'd0;
    rd_col  = 6'd1;
    we      = 1'b1;
    char_in = 8'h4D;
    step();
    check("midrst_char_out_before", char_out, 8'h41);
    #2;
    reset = 1'b1;
    #1;
    cursor(4'd0, 6'd0, "midrst_cursor");
    check("midrst_char_out", char_out, 8'h00);
    check("midrst_push_up", push_up, 1'b0);
    check("midrst_reset_call", reset_call, 1'b0);
    we    = 1'b0;
    reset = 1'b0;
    read(4'd0, 6'd0, 8'h00, "midrst_r0c0_blank");
    read(4'd0, 6'd5, 8'h00, "midrst_r0c5_blank");
    cursor(4'd0, 6'd0, "midrst_cursor_hold");

    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
